// File: rtl/stage5_hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: resolves load-use, memory-wait,
// fetch-wait and mispredict-redirect hazards that forwarding cannot cover.
module stage5_hazard_unit #(
    parameter int COUNT_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [4:0]         rs1_d,
    input  logic [4:0]         rs2_d,
    input  logic               rs1_used_d,
    input  logic               rs2_used_d,
    input  logic [4:0]         rd_e,
    input  logic               reg_write_e,
    input  logic               load_e,
    input  logic               mispredict_e,
    input  logic               dmem_busy_m,
    input  logic               imem_busy_f,
    output logic               stall_f,
    output logic               stall_d,
    output logic               stall_e,
    output logic               stall_m,
    output logic               flush_d,
    output logic               flush_e,
    output logic               flush_wb,
    output logic               redirect_f,
    output logic [COUNT_W-1:0] lu_stalls,
    output logic [COUNT_W-1:0] mem_stalls
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } fsm_t;

    fsm_t               fsm_r;
    fsm_t               fsm_nxt_s;
    logic               pending_r;
    logic               pending_nxt_s;
    logic [COUNT_W-1:0] lu_cnt_r;
    logic [COUNT_W-1:0] mem_cnt_r;

    logic lu_s;
    logic redir_req_s;
    logic redir_take_s;
    logic lu_take_s;
    logic mem_take_s;
    logic in_discard_s;

    logic stall_f_s;
    logic stall_d_s;
    logic stall_e_s;
    logic stall_m_s;
    logic flush_d_s;
    logic flush_e_s;
    logic flush_wb_s;
    logic redirect_f_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        if (v == {COUNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Load-use detection; x0 is never a real dependency.
    always_comb begin
        lu_s = 1'b0;
        if (load_e && reg_write_e && (rd_e != 5'd0)) begin
            lu_s = (rs1_used_d && (rs1_d == rd_e)) || (rs2_used_d && (rs2_d == rd_e));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Decode the discard state.
    always_comb begin
        in_discard_s = 1'b0;
        case (fsm_r)
            ST_RUN:     in_discard_s = 1'b0;
            ST_DISCARD: in_discard_s = 1'b1;
            default:    in_discard_s = 1'b0;
        endcase
    end

    assign redir_req_s = mispredict_e | pending_r;

    // Prioritised hazard resolution and next-state selection, zero latency.
    always_comb begin
        stall_f_s     = 1'b0;
        stall_d_s     = 1'b0;
        stall_e_s     = 1'b0;
        stall_m_s     = 1'b0;
        flush_d_s     = 1'b0;
        flush_e_s     = 1'b0;
        flush_wb_s    = 1'b0;
        redirect_f_s  = 1'b0;
        redir_take_s  = 1'b0;
        lu_take_s     = 1'b0;
        mem_take_s    = 1'b0;
        pending_nxt_s = pending_r;
        fsm_nxt_s     = fsm_r;
        if (RST) begin
            pending_nxt_s = 1'b0;
            fsm_nxt_s     = ST_RUN;
        end else begin
            if (dmem_busy_m) begin
                // Whole pipe frozen; a mispredict seen now is remembered for later.
                stall_f_s     = 1'b1;
                stall_d_s     = 1'b1;
                stall_e_s     = 1'b1;
                stall_m_s     = 1'b1;
                flush_wb_s    = 1'b1;
                pending_nxt_s = pending_r | mispredict_e;
                mem_take_s    = 1'b1;
            end else if (redir_req_s) begin
                redirect_f_s  = 1'b1;
                flush_d_s     = 1'b1;
                flush_e_s     = 1'b1;
                pending_nxt_s = 1'b0;
                redir_take_s  = 1'b1;
            end else if (lu_s) begin
                stall_f_s = 1'b1;
                stall_d_s = 1'b1;
                flush_e_s = 1'b1;
                lu_take_s = 1'b1;
            end else if (imem_busy_f) begin
                stall_f_s = 1'b1;
                flush_d_s = 1'b1;
            end else begin
                stall_f_s = 1'b0;
            end

            // The fetch in flight at redirect time is stale until it returns.
            if (in_discard_s) begin
                flush_d_s = 1'b1;
            end else begin
                flush_d_s = flush_d_s;
            end

            if (imem_busy_f && (in_discard_s || redir_take_s)) begin
                fsm_nxt_s = ST_DISCARD;
            end else begin
                fsm_nxt_s = ST_RUN;
            end
        end
    end

    // State, pending-redirect latch and performance counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_r     <= ST_RUN;
            pending_r <= 1'b0;
            lu_cnt_r  <= {COUNT_W{1'b0}};
            mem_cnt_r <= {COUNT_W{1'b0}};
        end else begin
            fsm_r     <= fsm_nxt_s;
            pending_r <= pending_nxt_s;
            if (lu_take_s) begin
                lu_cnt_r <= sat_inc(lu_cnt_r);
            end
            if (mem_take_s) begin
                mem_cnt_r <= sat_inc(mem_cnt_r);
            end
        end
    end

    assign stall_f    = stall_f_s;
    assign stall_d    = stall_d_s;
    assign stall_e    = stall_e_s;
    assign stall_m    = stall_m_s;
    assign flush_d    = flush_d_s;
    assign flush_e    = flush_e_s;
    assign flush_wb   = flush_wb_s;
    assign redirect_f = redirect_f_s;
    assign lu_stalls  = lu_cnt_r;
    assign mem_stalls = mem_cnt_r;

endmodule

// File: tb/tb_stage5_hazard_unit.sv
// Table-driven bench for stage5_hazard_unit with an expected-result queue.
module tb_stage5_hazard_unit;

    localparam int CW = 4;

    // Control bit order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_wb, redirect_f}
    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_MEM   = 8'b1111_0010;
    localparam logic [7:0] C_REDIR = 8'b0000_1101;
    localparam logic [7:0] C_LU    = 8'b1100_0100;
    localparam logic [7:0] C_IBUSY = 8'b1000_1000;
    localparam logic [7:0] C_DISC  = 8'b0000_1000;

    typedef struct {
        string          name;
        logic           rst;
        logic [4:0]     rs1;
        logic           u1;
        logic [4:0]     rs2;
        logic           u2;
        logic [4:0]     rd;
        logic           rw;
        logic           ld;
        logic           mp;
        logic           db;
        logic           ib;
        logic [7:0]     exp_ctl;
        logic [CW-1:0]  exp_lu;
        logic [CW-1:0]  exp_mem;
    } vec_t;

    typedef struct {
        string          name;
        logic [7:0]     ctl;
        logic [CW-1:0]  lu;
        logic [CW-1:0]  mem;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic [4:0]    rs1_d, rs2_d, rd_e;
    logic          rs1_used_d, rs2_used_d, reg_write_e, load_e;
    logic          mispredict_e, dmem_busy_m, imem_busy_f;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_wb, redirect_f;
    logic [CW-1:0] lu_stalls, mem_stalls;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    stage5_hazard_unit #(.COUNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d), .rs2_used_d(rs2_used_d),
        .rd_e(rd_e), .reg_write_e(reg_write_e), .load_e(load_e),
        .mispredict_e(mispredict_e), .dmem_busy_m(dmem_busy_m), .imem_busy_f(imem_busy_f),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_wb(flush_wb), .redirect_f(redirect_f),
        .lu_stalls(lu_stalls), .mem_stalls(mem_stalls)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(string name, logic rst, logic [4:0] rs1, logic u1,
                                logic [4:0] rs2, logic u2, logic [4:0] rd, logic rw, logic ld,
                                logic mp, logic db, logic ib, logic [7:0] ctl, int l, int m);
        vec_t v;
        v.name = name; v.rst = rst; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.ld = ld; v.mp = mp; v.db = db; v.ib = ib;
        v.exp_ctl = ctl; v.exp_lu = CW'(l); v.exp_mem = CW'(m);
        return v;
    endfunction

    function automatic vec_t idle(string name, int l, int m);
        return mk(name, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                  1'b0, 1'b0, 1'b0, C_NONE, l, m);
    endfunction

    function automatic vec_t ev(string name, logic mp, logic db, logic ib,
                                logic [7:0] ctl, int l, int m);
        return mk(name, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                  mp, db, ib, ctl, l, m);
    endfunction

    task automatic apply(input vec_t v);
        exp_t e;
        exp_t got;
        logic [7:0] ctl;
        RST = v.rst; rs1_d = v.rs1; rs1_used_d = v.u1; rs2_d = v.rs2; rs2_used_d = v.u2;
        rd_e = v.rd; reg_write_e = v.rw; load_e = v.ld;
        mispredict_e = v.mp; dmem_busy_m = v.db; imem_busy_f = v.ib;
        e.name = v.name; e.ctl = v.exp_ctl; e.lu = v.exp_lu; e.mem = v.exp_mem;
        sb.push_back(e);
        @(negedge CLK);
        got = sb.pop_front();
        ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_wb, redirect_f};
        n_tests++;
        if (ctl !== got.ctl) begin
            n_fail++;
            $display("FAIL %s ctl: got %b expected %b", got.name, ctl, got.ctl);
        end
        n_tests++;
        if (lu_stalls !== got.lu) begin
            n_fail++;
            $display("FAIL %s lu_stalls: got %0d expected %0d", got.name, lu_stalls, got.lu);
        end
        n_tests++;
        if (mem_stalls !== got.mem) begin
            n_fail++;
            $display("FAIL %s mem_stalls: got %0d expected %0d", got.name, mem_stalls, got.mem);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Load-use and reset behaviour
        tbl.push_back(mk("rst_dominates", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                         1'b1, 1'b1, 1'b1, C_NONE, 0, 0));
        tbl.push_back(idle("post_rst", 0, 0));
        tbl.push_back(mk("lu_rs2", 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b0, C_LU, 0, 0));
        tbl.push_back(idle("lu_rs2_after", 1, 0));
        tbl.push_back(mk("lu_rd0", 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b0, C_NONE, 1, 0));
        tbl.push_back(mk("lu_rs1", 1'b0, 5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b0, C_LU, 1, 0));
        tbl.push_back(idle("lu_rs1_after", 2, 0));
        tbl.push_back(mk("lu_unused", 1'b0, 5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b0, C_NONE, 2, 0));
        tbl.push_back(mk("lu_noload", 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0,
                         1'b0, 1'b0, 1'b0, C_NONE, 2, 0));
        tbl.push_back(mk("lu_nowrite", 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1,
                         1'b0, 1'b0, 1'b0, C_NONE, 2, 0));
        // Data-memory wait
        for (int k = 0; k < 3; k++) tbl.push_back(ev("dmem_wait", 1'b0, 1'b1, 1'b0, C_MEM, 2, k));
        tbl.push_back(idle("dmem_done", 2, 3));
        // Deferred redirect
        tbl.push_back(ev("defer_0", 1'b1, 1'b1, 1'b0, C_MEM, 2, 3));
        tbl.push_back(ev("defer_1", 1'b0, 1'b1, 1'b0, C_MEM, 2, 4));
        tbl.push_back(ev("defer_fire", 1'b0, 1'b0, 1'b0, C_REDIR, 2, 5));
        tbl.push_back(idle("defer_cleared", 2, 5));
        // Fetch discard
        tbl.push_back(ev("disc_redir", 1'b1, 1'b0, 1'b1, C_REDIR, 2, 5));
        tbl.push_back(ev("disc_busy1", 1'b0, 1'b0, 1'b1, C_IBUSY, 2, 5));
        tbl.push_back(ev("disc_busy2", 1'b0, 1'b0, 1'b1, C_IBUSY, 2, 5));
        tbl.push_back(ev("disc_return", 1'b0, 1'b0, 1'b0, C_DISC, 2, 5));
        tbl.push_back(idle("disc_run", 2, 5));
        // Redirect beats load-use
        tbl.push_back(mk("prio_redir_lu", 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1,
                         1'b1, 1'b0, 1'b0, C_REDIR, 2, 5));
        tbl.push_back(idle("prio_after", 2, 5));
        // Second mispredict while pending
        tbl.push_back(ev("pend2_0", 1'b1, 1'b1, 1'b0, C_MEM, 2, 5));
        tbl.push_back(ev("pend2_1", 1'b1, 1'b1, 1'b0, C_MEM, 2, 6));
        tbl.push_back(ev("pend2_fire", 1'b0, 1'b0, 1'b0, C_REDIR, 2, 7));
        tbl.push_back(idle("pend2_single", 2, 7));
        // Redirect again while discarding
        tbl.push_back(ev("rr_0", 1'b1, 1'b0, 1'b1, C_REDIR, 2, 7));
        tbl.push_back(ev("rr_1", 1'b1, 1'b0, 1'b1, C_REDIR, 2, 7));
        tbl.push_back(ev("rr_2", 1'b1, 1'b0, 1'b0, C_REDIR, 2, 7));
        tbl.push_back(idle("rr_run", 2, 7));
        // Counter saturation
        for (int k = 0; k < 14; k++)
            tbl.push_back(mk("lu_sat", 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1,
                             1'b0, 1'b0, 1'b0, C_LU, (2 + k > 15) ? 15 : 2 + k, 7));
        tbl.push_back(idle("lu_sat_hold", 15, 7));
        for (int k = 0; k < 10; k++)
            tbl.push_back(ev("mem_sat", 1'b0, 1'b1, 1'b0, C_MEM, 15, (7 + k > 15) ? 15 : 7 + k));
        tbl.push_back(idle("mem_sat_hold", 15, 15));

        RST = 1'b1; rs1_d = 5'd0; rs2_d = 5'd0; rd_e = 5'd0;
        rs1_used_d = 1'b0; rs2_used_d = 1'b0; reg_write_e = 1'b0; load_e = 1'b0;
        mispredict_e = 1'b0; dmem_busy_m = 1'b0; imem_busy_f = 1'b0;
        @(posedge CLK);
        #1;

        foreach (tbl[i]) apply(tbl[i]);

        // Load-use while discarding a stale fetch
        apply(ev("lud_redir", 1'b1, 1'b0, 1'b1, C_REDIR, 15, 15));
        apply(mk("lud_lu", 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1,
                 1'b0, 1'b0, 1'b1, 8'b1100_1100, 15, 15));
        apply(ev("lud_return", 1'b0, 1'b0, 1'b0, C_DISC, 15, 15));
        apply(idle("lud_run", 15, 15));

        // Reset while pending and discarding abandons everything
        apply(ev("mr_redir", 1'b1, 1'b0, 1'b1, C_REDIR, 15, 15));
        apply(ev("mr_pend", 1'b1, 1'b1, 1'b1, 8'b1111_1010, 15, 15));
        apply(mk("mr_rst", 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b1, C_NONE, 15, 15));
        apply(ev("mr_after_busy", 1'b0, 1'b0, 1'b1, C_IBUSY, 0, 0));
        apply(idle("mr_no_redirect", 0, 0));
        apply(idle("mr_quiet", 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stage5_hazard_unit.md
Name: stage5_hazard_unit

Overview:
- Stall/flush controller for the 5-stage pipeline. It is the complement of the forwarding unit: it handles every hazard that forwarding cannot resolve.
- Hazards covered: load-use, data-memory wait, instruction-fetch wait, and branch mispredict redirect.
- Sits beside the forwarding unit. It drives the per-stage stall and bubble-insert controls and the fetch redirect strobe.
- Holds a deferred-redirect latch, a fetch-discard state machine and saturating stall counters.

Parameters:
COUNT_W, 16, width of each saturating performance counter

Ports:
CLK  in  1  pipeline clock
RST  in  1  reset, synchronous, active-high
rs1_d  in  5  decode rs1 index
rs2_d  in  5  decode rs2 index
rs1_used_d  in  1  decode instruction reads rs1
rs2_used_d  in  1  decode instruction reads rs2
rd_e  in  5  execute destination index
reg_write_e  in  1  execute instruction writes rd
load_e  in  1  execute instruction is a load
mispredict_e  in  1  one-cycle pulse: branch/jump in E resolved mispredicted
dmem_busy_m  in  1  data access in M not yet complete
imem_busy_f  in  1  instruction fetch outstanding, no data this cycle
stall_f  out  1  hold PC / F register
stall_d  out  1  hold F/D register
stall_e  out  1  hold D/E register
stall_m  out  1  hold E/M register
flush_d  out  1  load bubble into F/D register at next edge
flush_e  out  1  load bubble into D/E register
flush_wb  out  1  load bubble into M/WB register
redirect_f  out  1  fetch takes the corrected PC this edge
lu_stalls  out  COUNT_W  load-use stall cycles, saturating
mem_stalls  out  COUNT_W  dmem wait cycles, saturating

Behaviour:
- Clocking/reset: one clock, CLK; reset RST is synchronous and active-high. RST clears state to RUN, clears pending, zeroes both counters; all outputs 0 during and after reset until inputs demand otherwise. RST mid-stall abandons all state, including any pending redirect.
- Stall/flush precedence: when stall_x and flush_x are both 1, flush wins (the register loads a bubble).
- Load-use hazard lu (combinational):
  - lu = load_e & reg_write_e & (rd_e!=0) & ((rs1_used_d & rs1_d==rd_e) | (rs2_used_d & rs2_d==rd_e)).
  - rd_e==0 is never a hazard.
- Registered state: fsm ∈ {RUN, DISCARD}; pending (1 bit); two counters.
- redir_req = mispredict_e | pending.
- Priority, evaluated every cycle, all decisions combinational, zero latency:
  1. dmem_busy_m=1:
     - stall_f=stall_d=stall_e=stall_m=1, flush_wb=1, redirect_f=0.
     - mispredict_e sets pending.
     - mem_stalls++.
  2. else if redir_req:
     - redirect_f=1, flush_d=1, flush_e=1; pending cleared; lu ignored.
     - If imem_busy_f=1 this cycle, next fsm=DISCARD.
  3. else if lu:
     - stall_f=stall_d=1, flush_e=1 (exactly one bubble per hazard; the forwarding unit then supplies the value from WB).
     - lu_stalls++.
  4. else if imem_busy_f:
     - stall_f=1, flush_d=1.
- DISCARD state:
  - flush_d=1 every cycle, so the stale in-flight fetch is squashed.
  - Exit to RUN on the first cycle with imem_busy_f=0; that cycle's returned instruction is also flushed.
  - The rules above still apply in DISCARD.
  - A new redir_req in DISCARD: redirect_f=1 again; stay in DISCARD if imem_busy_f=1, else go to RUN.
- Simultaneous events:
  - mispredict_e and dmem_busy_m rise in the same cycle → pending set, no redirect; the redirect fires on the first non-busy cycle.
  - Second mispredict_e while pending → pending stays 1 (a single redirect; the fetch unit holds the latest target).
- Counters: +1 per qualifying cycle; saturate at all-ones and never wrap.

Test Plan:
- Load-use: load_e=1, reg_write_e=1, rd_e=5, rs2_d=5, rs2_used_d=1 → one cycle stall_f=stall_d=flush_e=1; lu_stalls 0→1. With rd_e=0 → no stall.
- Dmem wait: dmem_busy_m=1 for 3 cycles → stall_f/d/e/m=1 and flush_wb=1 each cycle; mem_stalls=3; outputs all 0 on cycle 4.
- Deferred redirect: mispredict_e pulse coincident with dmem_busy_m=1 (2 cycles) → redirect_f=0 for both busy cycles; redirect_f=flush_d=flush_e=1 on cycle 3; pending=0 after.
- Fetch discard: mispredict_e with imem_busy_f=1 for 2 more cycles → flush_d=1 for the redirect cycle plus through the cycle imem_busy_f falls; fsm back to RUN.
- Priority: lu and mispredict_e together → redirect only, lu_stalls unchanged. Force lu_stalls to all-ones → further load-use does not wrap.
- Reset mid-operation: assert RST while pending=1 in DISCARD → next cycle all outputs 0, counters 0, no later redirect.
